cpu_bus_master: RTL and testbench
=================================

CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 Parameter RESET_ADDR, default 32'hBFC00000: value of address while idle after reset.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-004 req_valid  input  1  CPU requests an access.
REQ-005 req_write  input  1  1=store, 0=load.
REQ-006 req_size  input  2  access_size_t: BYTE=0, HALF=1, WORD=2; the value 3 is illegal.
REQ-007 req_signed  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 req_addr  input  32  byte address (size_t).
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 req_ready  output  1  block can accept a request.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_err  output  1  qualifies resp_valid: misaligned access or illegal size.
REQ-013 resp_rdata  output  32  extended load result; valid while resp_valid=1.
REQ-014 address  output  32  word-aligned bus address.
REQ-015 read / write  output  1 each  bus strobes, mutually exclusive.
REQ-016 byteenable  output  4  active byte lanes; little-endian (lane 0 = address+0).
REQ-017 writedata  output  32  lane-steered store data.
REQ-018 readdata  input  32  responder data, registered one cycle after the read is accepted.
REQ-019 waitrequest  input  1  responder stall.

Function
REQ-020 FSM states: IDLE, BUS, RDATA, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE: on req_valid=1, latch all req_* fields; go to BUS if aligned, else to RESP with err=1.
REQ-022 Alignment: HALF requires addr[0]=0, WORD requires addr[1:0]=0; req_size=3 is an error.
REQ-023 Error responses issue no bus strobe.
REQ-024 BUS: hold read or write, address={addr[31:2],2'b00}, byteenable and writedata stable until a cycle with waitrequest=0 (acceptance).
REQ-025 On acceptance: a store goes to RESP; a load goes to RDATA.
REQ-026 RDATA: read=write=0; capture extracted readdata at end of cycle; go to RESP.
REQ-027 RESP: resp_valid=1 for exactly one cycle, then IDLE; no response back-pressure.
REQ-028 Latency with zero waits, counted from the request-accept edge: store resp_valid in cycle 2; load resp_valid in cycle 3; each waitrequest=1 cycle in BUS adds 1.
REQ-029 Byteenable by size and addr[1:0]:
  - BYTE: 4'b0001<<addr[1:0];
  - HALF: 4'b0011<<addr[1:0];
  - WORD: 4'b1111.
REQ-030 writedata: req_wdata shifted left by 8*addr[1:0]; non-enabled lanes replicate the data.
REQ-031 Load extraction: readdata shifted right by 8*addr[1:0], truncated to 8/16/32 bits, then extended per req_signed.
REQ-032 read and write are never asserted outside BUS; byteenable=0 outside BUS.
REQ-033 req_valid outside IDLE is ignored; the CPU must hold it until req_ready.

Reset
REQ-034 reset=0 forces, immediately and asynchronously:
  - state IDLE;
  - read=0, write=0, byteenable=0;
  - resp_valid=0, resp_err=0, resp_rdata=0;
  - address=RESET_ADDR, writedata=0.
REQ-035 Reset mid-BUS abandons the access; no response is issued after reset deasserts.

Structure
REQ-036 access_size_t enum and the state enum live in the shared codes package, alongside size_t.
REQ-037 Lane steering (REQ-029..031) lives in one combinational sub-module, mem_lane_align, instanced once.

Verification
REQ-038 Responder is the team CPU RAM model (RAM_OFFSET 32'hBFC00000), run with RAM_WAIT=0 and with RAM_WAIT=1.
REQ-039 Word store 0xDEADBEEF @0xBFC00010, then word load -> byteenable 4'b1111, resp_rdata=0xDEADBEEF, store resp cycle 2, load resp cycle 3 with RAM_WAIT=0.
REQ-040 Byte store 0x80 @0xBFC00013, signed byte load -> byteenable 4'b1000, writedata[31:24]=0x80, resp_rdata=0xFFFFFF80; unsigned load -> 0x00000080.
REQ-041 Half load @0xBFC00011 -> resp_err=1 in cycle 1, read never asserted.
REQ-042 RAM_WAIT=1, 200 random aligned accesses vs a scoreboard -> all data match; strobes and address stable throughout waitrequest=1.
REQ-043 reset=0 while write=1 and waitrequest=1 -> write=0 in the same cycle, no resp_valid; next request completes normally.

Source files
------------

// File: rtl/cpu_bus_master_pkg.sv
// rtl/cpu_bus_master_pkg.sv - shared codes for the CPU bus master: sizes, states, alignment check
package cpu_bus_master_pkg;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RDATA,
    ST_RESP
  } bus_state_t;

  // Raw size code is checked before the enum cast so the illegal code 3 is caught.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    access_bad = 1'b0;
      2'd1:    access_bad = lo[0];
      2'd2:    access_bad = (lo != 2'b00);
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module mem_lane_align
  import cpu_bus_master_pkg::*;
(
  input  access_size_t size_i,
  input  logic [1:0]   lo_i,
  input  logic         sign_i,
  input  logic [31:0]  wdata_i,
  input  logic [31:0]  rdata_i,
  output logic [3:0]   be_o,
  output logic [31:0]  wdata_o,
  output logic [31:0]  rdata_o
);

  logic [31:0] shifted;

  // Replicating the narrow datum equals shifting it into place with copies in the idle lanes.
  always_comb begin
    shifted = rdata_i >> {lo_i, 3'b000};
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_bus_master.sv
// rtl/cpu_bus_master.sv - CPU load/store to word-bus master with waitrequest and byte enables
module cpu_bus_master
  import cpu_bus_master_pkg::*;
#(
  parameter size_t RESET_ADDR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  bus_state_t   state_q, state_d;
  logic         write_q, signed_q, err_q;
  access_size_t size_q;
  logic [31:0]  addr_q, wdata_q, rdata_q, address_q;
  logic [3:0]   be_lane;
  logic [31:0]  wdata_lane, rdata_lane;
  logic         req_bad;

  assign req_bad = access_bad(req_size, req_addr[1:0]);

  mem_lane_align u_lane (
    .size_i  (size_q),
    .lo_i    (addr_q[1:0]),
    .sign_i  (signed_q),
    .wdata_i (wdata_q),
    .rdata_i (readdata),
    .be_o    (be_lane),
    .wdata_o (wdata_lane),
    .rdata_o (rdata_lane)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = req_bad ? ST_RESP : ST_BUS;
      ST_BUS:   if (!waitrequest) state_d = write_q ? ST_RESP : ST_RDATA;
      ST_RDATA: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      address_q <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= req_bad;
        size_q   <= access_size_t'(req_size);
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        // Error responses never reach the bus, so the bus address keeps its old value.
        if (!req_bad) address_q <= {req_addr[31:2], 2'b00};
      end
      if (state_q == ST_RDATA) rdata_q <= rdata_lane;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign address    = address_q;
  assign read       = (state_q == ST_BUS) && !write_q;
  assign write      = (state_q == ST_BUS) && write_q;
  assign byteenable = (state_q == ST_BUS) ? be_lane : 4'b0000;
  assign writedata  = (state_q == ST_BUS) ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb/tb_cpu_bus_master.sv - scoreboard bench for cpu_bus_master against a CPU RAM model
module tb_cpu_bus_master;

  localparam logic [31:0] RAM_OFFSET = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, read, write, waitrequest;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic [3:0]  byteenable;

  cpu_bus_master #(.RESET_ADDR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .address(address),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPU RAM model: RAM_WAIT stall cycles per access, read data registered one cycle later.
  int          ram_wait = 0;
  int          wcnt = 0;
  logic [31:0] ram [0:255];
  logic [31:0] ram_off;
  logic [7:0]  ram_idx;

  assign ram_off     = address - RAM_OFFSET;
  assign ram_idx     = ram_off[9:2];
  assign waitrequest = (read | write) && (wcnt < ram_wait);

  always @(posedge clk) begin
    if (read | write) begin
      if (waitrequest) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        if (write)
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) ram[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
        if (read) readdata <= ram[ram_idx];
      end
    end else wcnt <= 0;
  end

  // Reference memory and scoreboard, driven from the request side only.
  logic [7:0] ref_b [0:1023];
  typedef struct {logic is_load; logic err; logic [31:0] rdata;} exp_t;
  exp_t sb[$];

  logic        saw_strobe = 1'b0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0, last_addr = 32'h0;
  logic [69:0] snap = '0;
  logic        pend = 1'b0;
  exp_t        got_e;

  always @(negedge clk) begin
    if (!reset) pend = 1'b0;
    else begin
      if (pend) begin
        chk("hold_stable", {read, write, address, byteenable, writedata}, snap);
        pend = 1'b0;
      end
      if ((read | write) && waitrequest) begin
        snap = {read, write, address, byteenable, writedata};
        pend = 1'b1;
      end
      if (read | write) begin
        saw_strobe = 1'b1;
        last_be    = byteenable;
        last_wd    = writedata;
        last_addr  = address;
      end
      if (read && write) chk("rw_exclusive", 1, 0);
      if (resp_valid) begin
        if (sb.size() == 0) chk("sb_unexpected_resp", 1, 0);
        else begin
          got_e = sb.pop_front();
          chk("resp_err", resp_err, got_e.err);
          if (got_e.is_load && !got_e.err) chk("resp_rdata", resp_rdata, got_e.rdata);
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int o = int'(a[9:0]);
    logic [31:0] v;
    case (sz)
      2'd0:    v = {{24{sg & ref_b[o][7]}}, ref_b[o]};
      2'd1:    v = {{16{sg & ref_b[o+1][7]}}, ref_b[o+1], ref_b[o]};
      default: v = {ref_b[o+3], ref_b[o+2], ref_b[o+1], ref_b[o]};
    endcase
    return v;
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic bad;
    exp_t e;
    int   t, lat, exp_lat;
    int   o;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    o   = int'(a[9:0]);
    e.is_load = !w;
    e.err     = bad;
    e.rdata   = 32'h0;
    if (!bad && w) begin
      ref_b[o] = wd[7:0];
      if (sz >= 2'd1) ref_b[o+1] = wd[15:8];
      if (sz == 2'd2) begin ref_b[o+2] = wd[23:16]; ref_b[o+3] = wd[31:24]; end
    end
    if (!bad && !w) e.rdata = ref_load(sz, sg, a);
    exp_lat = bad ? 1 : (w ? 2 + ram_wait : 3 + ram_wait);
    sb.push_back(e);
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    saw_strobe = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 50);
    chk("latency", lat, exp_lat);
    if (bad) chk("err_no_strobe", saw_strobe, 0);
    else chk("bus_address", last_addr, {a[31:2], 2'b00});
  endtask

  logic [1:0]  r_sz;
  logic [31:0] r_a;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_strobes", {read, write, byteenable}, 0);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("rst_address", address, 32'hBFC00000);
    chk("rst_writedata", writedata, 0);
    reset = 1'b1;

    // Zero-wait directed accesses
    ram_wait = 0;
    do_req(1'b1, 2'd2, 1'b0, 32'hBFC00010, 32'hDEADBEEF);
    chk("word_store_be", last_be, 4'b1111);
    chk("word_store_wd", last_wd, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'hBFC00010, 32'h0);
    chk("word_load_be", last_be, 4'b1111);
    do_req(1'b1, 2'd0, 1'b0, 32'hBFC00013, 32'h00000080);
    chk("byte_store_be", last_be, 4'b1000);
    chk("byte_store_lane3", last_wd[31:24], 8'h80);
    do_req(1'b0, 2'd0, 1'b1, 32'hBFC00013, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'hBFC00013, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'hBFC00012, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'hBFC00011, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'hBFC00014, 32'h12345678);
    do_req(1'b1, 2'd2, 1'b0, 32'hBFC00016, 32'h12345678);

    // One-wait random accesses
    ram_wait = 1;
    for (int n = 0; n < 200; n++) begin
      r_sz = 2'($urandom_range(0, 2));
      r_a  = RAM_OFFSET + ($urandom_range(0, 63) << 2);
      if (r_sz == 2'd0) r_a[1:0] = 2'($urandom_range(0, 3));
      if (r_sz == 2'd1) r_a[1]   = 1'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)), r_a, $urandom);
    end

    // Reset in the middle of a stalled store
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'hBFC00200; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_write", {write, waitrequest}, 2'b11);
    reset = 1'b0;
    #1;
    chk("rst_mid_write", write, 0);
    chk("rst_mid_be", byteenable, 0);
    chk("rst_mid_address", address, 32'hBFC00000);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 0);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'hBFC00200, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'hBFC00200, 32'h0BADF00D);
    do_req(1'b0, 2'd1, 1'b1, 32'hBFC00202, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
